// File: rtl/tdc_measure_ctrl_if.sv
// -----------------------------------------------------------------------------
// tdc_measure_ctrl_if
//   Readout handshake between the TDC measurement controller (master) and
//   the readout logic (slave).
//
//   Handshake: the master raises result_valid with result/timeout_err stable
//   and keeps all three unchanged until a cycle with result_valid &
//   result_ready; that cycle is the single transfer. result_valid never drops
//   without a transfer. result_ready may be asserted at any time.
//
//   Signals:
//     result        master->slave  CNT_W  coarse interval in clk cycles
//     result_valid  master->slave  1      result and timeout_err are valid
//     timeout_err   master->slave  1      measurement aborted by timeout
//     result_ready  slave->master  1      consumer accepts result
// -----------------------------------------------------------------------------
interface tdc_measure_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             timeout_err;
    logic             result_ready;

    modport master (
        output result,
        output result_valid,
        output timeout_err,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        input  timeout_err,
        output result_ready
    );
endinterface

// File: rtl/tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_measure_ctrl
//   Sequences one coarse time-interval measurement between the start (x) and
//   stop (y) comparator hit channels of the TDC. Both asynchronous hits are
//   synchronised and edge-detected with identical latency, so that latency
//   cancels out of the measured interval.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     start_hit   in   async start hit (comparator output)
//     stop_hit    in   async stop hit (comparator output)
//     arm         in   request one measurement (honoured only in IDLE)
//     busy        out  high in ARMED or COUNT
//     meas_count  out  completed handshakes, wraps 255 -> 0
//     dbg_state   out  FSM state (0 IDLE, 1 ARMED, 2 COUNT, 3 DONE)
//     rd          if   readout handshake (master side)
//
//   The interface instance connected to rd must use the same CNT_W.
//   SYNC_STAGES must be at least 2. TIMEOUT must lie in 1 .. 2^CNT_W-1.
// -----------------------------------------------------------------------------
module tdc_measure_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_hit,
    input  logic                stop_hit,
    input  logic                arm,
    output logic                busy,
    output logic [7:0]          meas_count,
    output logic [1:0]          dbg_state,
    tdc_measure_ctrl_if.master  rd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C    = TIMEOUT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] TIMEOUT_M1_C = TIMEOUT_C - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------------
    // Hit synchronisers and rising-edge detectors
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] stop_sync_q;
    logic                   start_dly_q;
    logic                   stop_dly_q;
    logic                   start_edge;
    logic                   stop_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            start_dly_q  <= 1'b0;
            stop_dly_q   <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_hit};
            stop_sync_q  <= {stop_sync_q[SYNC_STAGES-2:0], stop_hit};
            start_dly_q  <= start_sync_q[SYNC_STAGES-1];
            stop_dly_q   <= stop_sync_q[SYNC_STAGES-1];
        end
    end

    assign start_edge = start_sync_q[SYNC_STAGES-1] & ~start_dly_q;
    assign stop_edge  = stop_sync_q[SYNC_STAGES-1] & ~stop_dly_q;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] result_q;
    logic [CNT_W-1:0] result_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [7:0]       meas_count_q;
    logic [7:0]       meas_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            meas_count_q <= 8'd0;
        end else begin
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            meas_count_q <= meas_count_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        meas_count_d = meas_count_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end

            ST_ARMED: begin
                // Start wins over a coincident stop; the stop is dropped.
                // cnt runs 0 .. TIMEOUT-1, giving exactly TIMEOUT wait cycles.
                if (start_edge) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == TIMEOUT_M1_C) begin
                    state_d   = ST_DONE;
                    result_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_COUNT: begin
                // cnt already holds the interval for a stop seen this cycle,
                // so a stop coinciding with cnt == TIMEOUT is still a valid result.
                if (stop_edge) begin
                    state_d   = ST_DONE;
                    result_d  = cnt_q;
                    timeout_d = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = ST_DONE;
                    result_d  = TIMEOUT_C;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                // result_valid is high throughout DONE, so ready alone marks
                // the transfer cycle. arm is deliberately not looked at here.
                if (rd.result_ready) begin
                    state_d      = ST_IDLE;
                    meas_count_d = meas_count_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy            = (state_q == ST_ARMED) || (state_q == ST_COUNT);
        rd.result_valid = (state_q == ST_DONE);
    end

    assign rd.result   = result_q;
    assign rd.timeout_err = timeout_q;
    assign meas_count  = meas_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_measure_ctrl
//   Directed bench for tdc_measure_ctrl with TIMEOUT=8, SYNC_STAGES=2.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that time.
//   A hit raised after edge E is acted on by the FSM at edge E+3, so the
//   measured interval equals the tick distance between raising start and stop.
// -----------------------------------------------------------------------------
module tb_tdc_measure_ctrl;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    // ---------------- clock / reset ----------------
    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start_hit = 1'b0;
    logic       stop_hit  = 1'b0;
    logic       arm       = 1'b0;
    logic       busy;
    logic [7:0] meas_count;
    logic [1:0] dbg_state;

    tdc_measure_ctrl_if #(.CNT_W(CNT_W)) rd_if ();

    tdc_measure_ctrl #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_hit  (start_hit),
        .stop_hit   (stop_hit),
        .arm        (arm),
        .busy       (busy),
        .meas_count (meas_count),
        .dbg_state  (dbg_state),
        .rd         (rd_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [7:0]       exp_meas = 8'd0;
    logic [CNT_W:0]   exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_result(input logic err, input logic [CNT_W-1:0] res);
        exp_q.push_back({err, res});
    endtask

    task automatic check_result(input string tag);
        logic [CNT_W:0] e;
        check({tag, "_queue"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"},  rd_if.result_valid, 1);
            check({tag, "_result"}, rd_if.result, e[CNT_W-1:0]);
            check({tag, "_err"},    rd_if.timeout_err, e[CNT_W]);
            check({tag, "_busy"},   busy, 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // One-tick hit pulses at chosen offsets; -1 means no pulse.
    task automatic hit_seq(input int n, input int start_t, input int stop_t0, input int stop_t1);
        for (int t = 0; t < n; t++) begin
            start_hit = (t == start_t);
            stop_hit  = (t == stop_t0) || (t == stop_t1);
            tick();
        end
        start_hit = 1'b0;
        stop_hit  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!rd_if.result_valid && n < budget) begin
            tick();
            n++;
        end
        if (!rd_if.result_valid) check({tag, "_wait_timeout"}, rd_if.result_valid, 1);
    endtask

    task automatic handshake(input string tag);
        rd_if.result_ready = 1'b1;
        tick();
        rd_if.result_ready = 1'b0;
        exp_meas = exp_meas + 8'd1;
        check({tag, "_hs_valid"}, rd_if.result_valid, 0);
        check({tag, "_hs_state"}, dbg_state, 0);
        check({tag, "_hs_count"}, meas_count, exp_meas);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rd_if.result_ready = 1'b0;

        // Reset state
        ticks(3);
        check("rst_busy",   busy, 0);
        check("rst_valid",  rd_if.result_valid, 0);
        check("rst_result", rd_if.result, 0);
        check("rst_err",    rd_if.timeout_err, 0);
        check("rst_count",  meas_count, 0);
        check("rst_state",  dbg_state, 0);
        rst_n = 1'b1;
        ticks(2);

        // Basic interval of 5 with exact valid latency
        expect_result(1'b0, 16'd5);
        arm_pulse();
        check("basic_armed", dbg_state, 1);
        check("basic_busy",  busy, 1);
        ticks(2);
        hit_seq(6, 0, 5, -1);
        tick();
        check("basic_not_yet", rd_if.result_valid, 0);
        tick();
        check_result("basic");
        handshake("basic");

        // Backpressure: hold result while arm/hits toggle
        ticks(4);
        expect_result(1'b0, 16'd3);
        arm_pulse();
        ticks(2);
        hit_seq(4, 0, 3, -1);
        wait_valid("bp", 30);
        check_result("bp");
        for (int i = 0; i < 20; i++) begin
            arm       = i[0];
            start_hit = i[1];
            stop_hit  = i[2];
            tick();
            check("bp_hold_valid",  rd_if.result_valid, 1);
            check("bp_hold_result", rd_if.result, 3);
            check("bp_hold_err",    rd_if.timeout_err, 0);
        end
        arm = 1'b0;
        start_hit = 1'b0;
        stop_hit = 1'b0;
        tick();
        // arm together with the handshake must not re-arm
        arm = 1'b1;
        handshake("bp");
        arm = 1'b0;
        tick();
        check("bp_no_rearm", dbg_state, 0);

        // Start timeout: 8 wait cycles, result 0 with error
        ticks(4);
        expect_result(1'b1, 16'd0);
        arm_pulse();
        check("sto_armed", dbg_state, 1);
        ticks(7);
        check("sto_not_yet", rd_if.result_valid, 0);
        check("sto_still_armed", dbg_state, 1);
        tick();
        check_result("sto");
        handshake("sto");

        // Stop timeout: result TIMEOUT with error
        ticks(2);
        expect_result(1'b1, 16'd8);
        arm_pulse();
        ticks(2);
        hit_seq(1, 0, -1, -1);
        ticks(9);
        check("ptmo_not_yet", rd_if.result_valid, 0);
        check("ptmo_counting", dbg_state, 2);
        tick();
        check_result("ptmo");
        handshake("ptmo");

        // Stop coincident with cnt == TIMEOUT: valid result
        ticks(2);
        expect_result(1'b0, 16'd8);
        arm_pulse();
        ticks(2);
        hit_seq(9, 0, 8, -1);
        tick();
        check("tie_not_yet", rd_if.result_valid, 0);
        tick();
        check_result("tie");
        handshake("tie");

        // Simultaneous start/stop, then stop 3 later
        ticks(2);
        expect_result(1'b0, 16'd3);
        arm_pulse();
        ticks(2);
        hit_seq(4, 0, 0, 3);
        wait_valid("simul", 30);
        check_result("simul");
        handshake("simul");

        // Stop before start is ignored
        ticks(2);
        expect_result(1'b0, 16'd4);
        arm_pulse();
        hit_seq(1, -1, 0, -1);
        ticks(4);
        check("early_stop_armed", dbg_state, 1);
        hit_seq(5, 0, 4, -1);
        wait_valid("early_stop", 30);
        check_result("early_stop");
        handshake("early_stop");

        // arm during COUNT does not restart
        ticks(2);
        expect_result(1'b0, 16'd6);
        arm_pulse();
        ticks(1);
        hit_seq(1, 0, -1, -1);
        ticks(3);
        check("arm_cnt_state", dbg_state, 2);
        arm_pulse();
        check("arm_cnt_no_restart", dbg_state, 2);
        tick();
        hit_seq(1, -1, 0, -1);
        wait_valid("arm_cnt", 30);
        check_result("arm_cnt");
        handshake("arm_cnt");

        // Asynchronous reset during COUNT
        ticks(2);
        arm_pulse();
        ticks(1);
        hit_seq(1, 0, -1, -1);
        ticks(4);
        check("rstmid_counting", dbg_state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy",   busy, 0);
        check("rstmid_state",  dbg_state, 0);
        check("rstmid_valid",  rd_if.result_valid, 0);
        check("rstmid_result", rd_if.result, 0);
        check("rstmid_err",    rd_if.timeout_err, 0);
        check("rstmid_count",  meas_count, 0);
        exp_meas = 8'd0;
        // Hits held high through reset release give edges in IDLE only
        start_hit = 1'b1;
        stop_hit  = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        ticks(6);
        check("held_hit_idle", dbg_state, 0);
        check("held_hit_busy", busy, 0);
        start_hit = 1'b0;
        stop_hit  = 1'b0;
        ticks(3);

        // 256 handshakes wrap meas_count
        rd_if.result_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            int n;
            arm_pulse();
            n = 0;
            while (meas_count != 8'(k + 1) && n < 30) begin
                tick();
                n++;
            end
            if (meas_count != 8'(k + 1)) check("wrap_step", meas_count, 8'(k + 1));
            if (k == 254) check("wrap_255", meas_count, 255);
        end
        rd_if.result_ready = 1'b0;
        check("wrap_zero",  meas_count, 0);
        check("wrap_idle",  dbg_state, 0);
        check("wrap_valid", rd_if.result_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_measure_ctrl.md
Name: tdc_measure_ctrl

Overview:
- Sequences one time-interval measurement across the two comparator hit channels of the FPGA TDC: start channel (x side) and stop channel (y side).
- Synchronises both asynchronous hits, arms on request, and counts coarse clock cycles from start edge to stop edge.
- Presents the result on a valid/ready handshake to the readout logic; aborts with an error flag on timeout.

Parameters:
- CNT_W, 16, width of coarse counter and result.
- TIMEOUT, 1000, max cycles waited in ARMED and in COUNT; legal range 1 .. 2^CNT_W-1.
- SYNC_STAGES, 2, synchroniser flops per hit input; must be >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_hit  in  1  async start hit, from comparator output.
- stop_hit  in  1  async stop hit, from comparator output.
- arm  in  1  request to start one measurement; sampled on clk.
- busy  out  1  high in ARMED or COUNT.
- result  out  CNT_W  coarse interval in clk cycles.
- result_valid  out  1  result and timeout_err are valid.
- result_ready  in  1  consumer accepts result.
- timeout_err  out  1  measurement aborted by timeout; qualified by result_valid.
- meas_count  out  8  completed handshakes; wraps 255 -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy, result, result_valid, timeout_err, meas_count, cnt and all synchroniser/edge flops go to 0.
- Input synchronisation:
  - Each hit passes through SYNC_STAGES flops plus one delay flop.
  - edge = synced & ~delayed.
  - Fixed latency SYNC_STAGES+1 cycles, identical on both channels, so it cancels in the interval.
  - A hit held high through reset release yields one edge. That edge is ignored unless it arrives in the relevant state.
- IDLE:
  - busy=0.
  - arm=1 -> ARMED, cnt<=0. Hit edges are ignored.
- ARMED:
  - busy=1. cnt increments each cycle as the wait timer.
  - Stop edges are ignored.
  - Start edge -> COUNT, cnt<=1. If start and stop edges arrive in the same cycle, start wins and the stop is discarded.
  - If cnt reaches TIMEOUT with no start edge -> DONE with result<=0, timeout_err<=1.
- COUNT:
  - busy=1.
  - Stop edge -> DONE with result<=cnt, timeout_err<=0. Result is the number of cycles between the start-edge cycle and the stop-edge cycle.
  - Otherwise cnt<=cnt+1. When cnt==TIMEOUT and no stop edge -> DONE with result<=TIMEOUT, timeout_err<=1.
  - If a stop edge and the timeout fall in the same cycle, the stop wins (valid result).
  - Further start edges are ignored.
- DONE:
  - result_valid=1, busy=0. result and timeout_err stay stable until the handshake.
  - Handshake cycle (result_valid & result_ready) -> IDLE: result_valid deasserts next cycle and meas_count increments.
  - arm is ignored in DONE, including the handshake cycle. A new arm is needed in IDLE.
- arm while busy: ignored, no restart.
- Reset mid-measurement aborts immediately. No result and no meas_count increment.
- cnt is CNT_W bits and never exceeds TIMEOUT, so no wrap.
- FSM: 2-bit encoding, IDLE=0, ARMED=1, COUNT=2, DONE=3.

Test Plan:
- Basic interval:
  - Stimulus: TIMEOUT=1000; arm at cycle 5; start_hit rises so its edge is detected at cycle 10; stop edge detected at cycle 15; result_ready=1.
  - Required: result_valid high from cycle 16 with result=5, timeout_err=0; meas_count=1 after the handshake.
- Backpressure:
  - Stimulus: result_ready=0 for 20 cycles after valid; toggle arm and both hits meanwhile.
  - Required: result, valid and timeout_err unchanged; on ready=1, one handshake and meas_count+1.
- Start timeout:
  - Stimulus: TIMEOUT=8; arm and no start hit.
  - Required: valid after 8 wait cycles with result=0, timeout_err=1.
- Stop timeout and ties:
  - Stimulus: TIMEOUT=8; start edge, no stop.
  - Required: result=8, timeout_err=1.
  - Stimulus: repeat with the stop edge in the same cycle cnt reaches 8.
  - Required: result=8, timeout_err=0.
- Simultaneous and ignored hits:
  - Stimulus: start and stop edges in the same cycle while ARMED, then a stop 3 cycles later.
  - Required: result=3.
  - Stimulus: stop edges before start.
  - Required: ignored.
  - Stimulus: arm during COUNT.
  - Required: no restart.
- Reset mid-op and wrap:
  - Stimulus: assert rst_n=0 asynchronously during COUNT.
  - Required: all outputs 0 immediately.
  - Stimulus: 256 completed handshakes.
  - Required: meas_count wraps to 0.
